// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall and operand forwarding selects from a 3-deep issue history (optional HAZ_ZERO_REG_EN keeps r0 from ever matching)
module hazard_forward_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [4:0] RA,
  input  logic [4:0] RB,
  input  logic       use_ra,
  input  logic       use_rb,
  input  logic [4:0] RW,
  input  logic       wr_en,
  input  logic       is_load,
  output logic       stall,
  output logic [1:0] mux_sel_A,
  output logic [1:0] mux_sel_B,
  output logic [4:0] RW_dm,
  output logic       wr_dm
);
  logic       h1_v, h2_v, h3_v, h1_l, issue;
  logic [4:0] h1_r, h2_r, h3_r;
  function automatic logic hit(input logic v, input logic [4:0] r, input logic [4:0] s, input logic u);
`ifdef HAZ_ZERO_REG_EN
    return u & v & (r == s) & (s != 5'd0);
`else
    return u & v & (r == s);
`endif
  endfunction
  function automatic logic [1:0] sel(input logic [4:0] s, input logic u);
    return hit(h1_v, h1_r, s, u) ? 2'b01 :
           hit(h2_v, h2_r, s, u) ? 2'b10 :
           hit(h3_v, h3_r, s, u) ? 2'b11 : 2'b00;
  endfunction
  // a load still one stage ahead cannot forward yet, so hold decode for one cycle
  always_comb begin
    stall = instr_valid & h1_l & (hit(h1_v, h1_r, RA, use_ra) | hit(h1_v, h1_r, RB, use_rb));
    issue = instr_valid & ~stall;
  end
  // shift the issue history and register operand selects against the pre-shift history
  always_ff @(posedge clk) begin
    if (rst) begin
      {h1_v, h2_v, h3_v, h1_l} <= '0;
      {h1_r, h2_r, h3_r} <= '0;
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
    end else begin
      {h3_v, h3_r} <= {h2_v, h2_r};
      {h2_v, h2_r} <= {h1_v, h1_r};
      {h1_v, h1_r, h1_l} <= {issue & wr_en, RW, is_load};
      mux_sel_A <= issue ? sel(RA, use_ra) : 2'b00;
      mux_sel_B <= issue ? sel(RB, use_rb) : 2'b00;
    end
  end
  assign RW_dm = h2_r;
  assign wr_dm = h2_v;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors with a queued scoreboard checked by an independent monitor
module tb_hazard_forward_unit;
  logic       clk, rst, instr_valid, use_ra, use_rb, wr_en, is_load, stall, wr_dm;
  logic [4:0] RA, RB, RW, RW_dm;
  logic [1:0] mux_sel_A, mux_sel_B;
`ifdef HAZ_ZERO_REG_EN
  localparam bit zr = 1'b1;
`else
  localparam bit zr = 1'b0;
`endif
  localparam int nv = 32;
  typedef struct {int st; int a; int b; int wr; int rw;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, done = 0;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .RA(RA), .RB(RB),
    .use_ra(use_ra), .use_rb(use_rb), .RW(RW), .wr_en(wr_en), .is_load(is_load),
    .stall(stall), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .RW_dm(RW_dm), .wr_dm(wr_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, n, act, exp);
    end
  endtask

  task automatic vec(input int r, input int iv, input int ra, input int rb, input int ua, input int ub,
                     input int w, input int we, input int ld,
                     input int est, input int ea, input int eb, input int ewr, input int erw);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r[0]; instr_valid = iv[0]; RA = 5'(ra); RB = 5'(rb); use_ra = ua[0]; use_rb = ub[0];
    RW = 5'(w); wr_en = we[0]; is_load = ld[0];
    e = '{est, ea, eb, ewr, erw};
    q.push_back(e);
  endtask

  // monitor: stall sampled mid-cycle, registered outputs just after the following edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", done, int'(stall), e.st);
        @(posedge clk);
        #1;
        chk("mux_sel_A", done, int'(mux_sel_A), e.a);
        chk("mux_sel_B", done, int'(mux_sel_B), e.b);
        chk("wr_dm", done, int'(wr_dm), e.wr);
        chk("RW_dm", done, int'(RW_dm), e.rw);
        done++;
      end
    end
  end

  initial begin
    {rst, instr_valid, use_ra, use_rb, wr_en, is_load} = '0;
    {RA, RB, RW} = '0;
    vec(1,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    vec(1,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 3,1,0,  0,0,0,0,0);
    vec(0,1,3,0,1,0, 10,1,0, 0,1,0,1,3);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,1,10);
    vec(0,1,0,0,0,0, 5,1,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 11,1,0, 0,0,0,1,5);
    vec(0,1,0,5,0,1, 0,0,0,  0,0,2,1,11);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 5,1,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 12,1,0, 0,0,0,1,5);
    vec(0,1,0,0,0,0, 13,1,0, 0,0,0,1,12);
    vec(0,1,0,5,0,1, 0,0,0,  0,0,3,1,13);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 7,1,1,  0,0,0,0,0);
    vec(0,1,7,0,1,0, 8,1,0,  1,0,0,1,7);
    vec(0,1,7,0,1,0, 8,1,0,  0,2,0,0,8);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,1,8);
    vec(0,1,0,0,0,0, 4,1,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 4,1,0,  0,0,0,1,4);
    vec(0,1,4,4,1,0, 0,0,0,  0,1,0,1,4);
    vec(0,1,4,4,0,1, 0,0,0,  0,0,2,0,0);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    vec(0,1,0,0,0,0, 2,1,1,  0,0,0,0,0);
    vec(1,1,2,0,1,0, 9,1,0,  1,0,0,0,0);
    vec(0,1,2,0,1,0, 9,1,0,  0,0,0,0,0);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,1,9);
    vec(0,1,0,0,0,0, 0,1,0,  0,0,0,0,0);
    vec(0,1,0,0,1,0, 0,0,0,  0,zr ? 0 : 1,0,1,0);
    vec(0,1,0,0,0,0, 0,1,1,  0,0,0,0,0);
    vec(0,1,0,0,0,1, 0,0,0,  zr ? 0 : 1,0,0,1,0);
    vec(0,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    for (int i = 0; i < 20 && done < nv; i++) @(posedge clk);
    #3;
    checks++;
    if (done != nv) begin
      fails++;
      $display("FAIL monitor_timeout: got %0d vectors checked expected %0d", done, nv);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
